// File: rtl/key_debounce_multi_pkg.sv
// key_pkg: shared types and constants for the multi-channel key debouncer.
//   chan_state_e    : per-channel debounce FSM state.
//   f_ms_to_cycles  : clock cycles per 1 ms tick for a given clock frequency.
//   f_bits_for      : safe $clog2 wrapper that never returns 0.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    HELD     = 3'd2,
    LONG     = 3'd3,
    REL_DB   = 3'd4
  } chan_state_e;

  function automatic int f_ms_to_cycles(input int clk_hz);
    return clk_hz / 1000;
  endfunction

  // Width needed to hold values 0..max_val, at least one bit.
  function automatic int f_bits_for(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_multi_if.sv
// key_debounce_multi_if: connection between the shared front end (synchroniser
// and tick divider) and one debounce channel.
//   tick  : one-cycle 1 ms strobe from the shared divider
//   s     : synchronised key level, active-low
//   level : debounced key level, active-low, idle 1
//   press / rel / lng / rpt : one-cycle event strobes
// Handshake: there is no back-pressure. Each strobe is a single-cycle
// valid-only pulse that the consumer must sample in the cycle it is high;
// the level signal is a plain registered level.
// modport master: the channel side (drives level and strobes).
// modport slave : the front-end side (drives tick and s).
interface key_debounce_multi_if;

  logic tick;
  logic s;
  logic level;
  logic press;
  logic rel;
  logic lng;
  logic rpt;

  modport master (
    input  tick,
    input  s,
    output level,
    output press,
    output rel,
    output lng,
    output rpt
  );

  modport slave (
    output tick,
    output s,
    input  level,
    input  press,
    input  rel,
    input  lng,
    input  rpt
  );

endinterface

// File: rtl/key_debounce_multi_chan.sv
// key_chan: one debounce channel. A five-state FSM plus a millisecond counter
// turns the synchronised active-low key level into a debounced level and
// press / release / long-press / auto-repeat strobes.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : key_debounce_multi_if.master (tick, s in; level, strobes out)
// Counting rule: the counter advances on ticks only, and a threshold fires on
// the tick that finds the counter already at the threshold. Any level change
// clears the counter in that cycle, even if a tick coincides with it.
module key_chan
  import key_pkg::*;
#(
  parameter int p_debounce_ms = 20,
  parameter int p_long_ms     = 1000,
  parameter int p_repeat_ms   = 200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  key_debounce_multi_if.master bus
);

  localparam int c_cnt_w = $clog2(p_long_ms + 1);
  localparam logic [c_cnt_w-1:0] c_db_last   = c_cnt_w'(p_debounce_ms);
  localparam logic [c_cnt_w-1:0] c_long_last = c_cnt_w'(p_long_ms);
  localparam logic [c_cnt_w-1:0] c_rep_last  = c_cnt_w'(p_repeat_ms);

  chan_state_e        state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               level_q, level_d;
  logic               press_q, press_d;
  logic               rel_q, rel_d;
  logic               lng_q, lng_d;
  logic               rpt_q, rpt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    lng_d   = 1'b0;
    rpt_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.s) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
      end

      PRESS_DB: begin
        if (bus.s) begin
          // Glitch shorter than the debounce window: drop it silently.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (bus.tick) begin
          if (cnt_q == c_db_last) begin
            state_d = HELD;
            cnt_d   = '0;
            press_d = 1'b1;
            level_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      HELD: begin
        if (bus.s) begin
          state_d = REL_DB;
          cnt_d   = '0;
        end else if (bus.tick) begin
          if (cnt_q == c_long_last) begin
            state_d = LONG;
            cnt_d   = '0;
            lng_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      LONG: begin
        if (bus.s) begin
          state_d = REL_DB;
          cnt_d   = '0;
        end else if ((p_repeat_ms > 0) && bus.tick) begin
          if (cnt_q == c_rep_last) begin
            cnt_d = '0;
            rpt_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      REL_DB: begin
        if (!bus.s) begin
          // Release bounce: the key is still down, long/repeat timing restarts.
          state_d = HELD;
          cnt_d   = '0;
        end else if (bus.tick) begin
          if (cnt_q == c_db_last) begin
            state_d = IDLE;
            cnt_d   = '0;
            rel_d   = 1'b1;
            level_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      lng_q   <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      lng_q   <= lng_d;
      rpt_q   <= rpt_d;
    end
  end

  assign bus.level = level_q;
  assign bus.press = press_q;
  assign bus.rel   = rel_q;
  assign bus.lng   = lng_q;
  assign bus.rpt   = rpt_q;

endmodule

// File: rtl/key_debounce_multi.sv
// key_debounce_multi: N-channel push-button debouncer for active-low keys.
// A 2-flop synchroniser per pin and one free-running 1 ms tick divider feed
// p_key_num independent key_chan instances.
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   i_key      : raw key pins (asynchronous, active-low)
//   o_key      : debounced levels, same polarity as i_key, idle all 1s
//   o_key_val  : high whenever any o_press or o_release bit is high
//   o_press, o_release, o_long, o_repeat : one-cycle per-channel strobes
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int p_system_clk  = 100_000_000,
  parameter int p_key_num     = 2,
  parameter int p_debounce_ms = 20,
  parameter int p_long_ms     = 1000,
  parameter int p_repeat_ms   = 200
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [p_key_num-1:0] i_key,
  output logic [p_key_num-1:0] o_key,
  output logic                 o_key_val,
  output logic [p_key_num-1:0] o_press,
  output logic [p_key_num-1:0] o_release,
  output logic [p_key_num-1:0] o_long,
  output logic [p_key_num-1:0] o_repeat
);

  localparam int c_tick_cycles = f_ms_to_cycles(p_system_clk);
  localparam int c_div_w       = f_bits_for(c_tick_cycles - 1);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_tick_cycles - 1);

  logic [p_key_num-1:0] sync1_q, sync1_d;
  logic [p_key_num-1:0] sync2_q, sync2_d;
  logic [c_div_w-1:0]   div_q, div_d;
  logic                 tick;

  // Synchroniser resets to the idle (released) level so reset never looks
  // like a press.
  always_comb begin
    sync1_d = i_key;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  always_comb begin
    tick  = (div_q == c_div_last);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  for (genvar g = 0; g < p_key_num; g++) begin : g_chan
    key_debounce_multi_if chan_if ();

    assign chan_if.tick = tick;
    assign chan_if.s    = sync2_q[g];

    key_chan #(
      .p_debounce_ms (p_debounce_ms),
      .p_long_ms     (p_long_ms),
      .p_repeat_ms   (p_repeat_ms)
    ) u_chan (
      .clk   (clk),
      .rst_n (rstn),
      .bus   (chan_if)
    );

    assign o_key[g]     = chan_if.level;
    assign o_press[g]   = chan_if.press;
    assign o_release[g] = chan_if.rel;
    assign o_long[g]    = chan_if.lng;
    assign o_repeat[g]  = chan_if.rpt;
  end

  assign o_key_val = |{o_press, o_release};

endmodule
